// File: rtl/cpu_prog_driver.sv
// Sequencing master for the lab CPU instruction interface: walks a program ROM and, for each
// instruction, drives cpu_in, pulses cpu_load then cpu_s, and waits out the CPU's w handshake.
module cpu_prog_driver #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       cpu_in,
  output logic              cpu_load,
  output logic              cpu_s,
  input  logic              cpu_w,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  // Last count value still tolerated; the following edge would make the count TIMEOUT-1.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StStrt, StWlow, StWhigh, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [15:0]       cin_q, cin_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      last_q  <= '0;
      cin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        // A run only launches once the CPU is sitting in its wait state.
        if (start && cpu_w) begin
          state_d = StFetch;
          pc_d    = '0;
          last_d  = last_addr;
        end
      end
      StFetch: begin
        cin_d   = rom_data;
        state_d = StLoad;
      end
      StLoad: state_d = StStrt;
      StStrt: begin
        cnt_d   = '0;
        state_d = StWlow;
      end
      StWlow: begin
        if (!cpu_w) begin
          cnt_d   = '0;
          state_d = StWhigh;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWhigh: begin
        if (cpu_w) begin
          if (pc_q == last_q) begin
            state_d = StDone;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs straight from the state register so reset clears them immediately.
  assign cpu_load = (state_q == StLoad);
  assign cpu_s    = (state_q == StStrt);
  assign done     = (state_q == StDone);
  assign err      = (state_q == StErr);
  assign busy     = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign cpu_in   = cin_q;
  assign pc       = pc_q;
  assign rom_addr = pc_q;

endmodule
